bus_initiator: RTL
==================

Name: bus_initiator

Overview:
- Master end of the byte-serial memory bus. Arbitrates between the instruction-fetch port and the load/store port of the core.
- Translates each granted request into one bus transaction (o_bus_DV pulse, address, data, bhw, write flag) and waits for the responder's i_bus_DV completion pulse.
- Formats read data: byte-lane masking and sign/zero extension. Detects hung transactions with a timeout.
- Sits between the CPU pipeline and memory_top.

Parameters:
- TIMEOUT_CYCLES, 4096: cycles in WAIT with no i_bus_DV before a fault is declared.
- CNT_W, 13: width of the timeout counter; must satisfy 2**CNT_W > TIMEOUT_CYCLES.

Ports:
- i_clk  input  1  system clock, rising edge
- i_rst  input  1  reset, asynchronous, active-high
- i_if_req  input  1  fetch request; held until o_if_ack
- i_if_addr  input  32  fetch address
- o_if_ack  output  1  one-cycle pulse; o_if_rdata valid in the same cycle
- o_if_rdata  output  32  fetched word
- i_ls_req  input  1  load/store request; held until o_ls_ack
- i_ls_we  input  1  1=store, 0=load
- i_ls_funct3  input  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- i_ls_addr  input  32  data address
- i_ls_wdata  input  32  store data, right-aligned
- o_ls_ack  output  1  one-cycle completion pulse
- o_ls_rdata  output  32  extended load data, valid with o_ls_ack
- o_bus_data  output  32  write data to responder
- o_bus_address  output  32  transaction start address
- o_bus_DV  output  1  one-cycle request strobe
- o_bhw  output  3  byte count: 100 word, 010 half, 001 byte
- o_write_notread  output  1  1=write
- i_bus_data  input  32  read data; byte k holds address+k
- i_bus_DV  input  1  one-cycle completion strobe from the responder
- o_fault  output  1  sticky timeout flag
- o_fault_addr  output  32  address of the hung transaction

Behaviour:
- Reset values:
  - All outputs 0; o_fault=0; state=IDLE.
  - Round-robin pointer last_grant=LS, so fetch wins the first tie.
- States: IDLE, ISSUE, WAIT, FAULT.
- IDLE:
  - If no request is pending, stay.
  - If only one port requests, grant it.
  - If both request, grant the port that is not last_grant.
  - Latch address, bhw, write flag and data into the bus registers; update last_grant; go to ISSUE.
- Invalid ls funct3 (011, 110, 111):
  - No bus transaction.
  - o_ls_ack=1 with o_ls_rdata=0 in the next cycle; stay IDLE.
- ISSUE: o_bus_DV=1 for exactly this cycle; clear the timeout counter; go to WAIT.
- Bus output hold: o_bus_address, o_bus_data, o_bhw and o_write_notread are registered and stay stable from ISSUE until the end of WAIT.
- WAIT:
  - Increment the counter each cycle.
  - On i_bus_DV: capture i_bus_data, pulse the granted port's ack in the next cycle, return to IDLE.
  - A new grant may occur in the same cycle as that ack.
  - Result: at most one transaction is ever outstanding. The responder ignores strobes while busy, so this is mandatory.
- Timeout:
  - If the counter reaches TIMEOUT_CYCLES in WAIT: set o_fault=1, o_fault_addr=o_bus_address, go to FAULT.
  - FAULT: no acks and no new strobes, since the responder is hung. Exit only via i_rst. i_bus_DV is ignored in FAULT.
- Width mapping:
  - Fetch and W → bhw 100.
  - H/HU → 010.
  - B/BU → 001.
- Store data placement: right-aligned, o_bus_data = i_ls_wdata unchanged. The responder takes the low bytes little-endian.
- Read formatting: the responder does not clear unused upper bytes, so the block masks them itself.
  - B: {{24{d[7]}}, d[7:0]}
  - BU: {24'b0, d[7:0]}
  - H: {{16{d[15]}}, d[15:0]}
  - HU: {16'b0, d[15:0]}
  - W and fetch: d unchanged.
- Alignment: no alignment checks; misaligned accesses are legal because the responder is byte-serial.
- Store completion: o_ls_ack after i_bus_DV; o_ls_rdata=0.
- Requester protocol:
  - A requester dropping req before ack is a protocol violation; the transaction completes anyway and the ack is still pulsed.
  - A spurious i_bus_DV in IDLE or ISSUE is ignored.
- Reset mid-transaction:
  - All state clears immediately.
  - The responder may still complete later; that stray i_bus_DV arrives in IDLE and is ignored.
- Minimum latency: request to ack = 3 cycles + responder latency (grant, ISSUE, WAIT≥1, ack).

Decomposition:
- Shared package/header holds:
  - BHW_WORD/BHW_HALF/BHW_BYTE constants
  - funct3 codes
  - state encodings
  - TIMEOUT_CYCLES default
- One natural sub-module: load_extender. Combinational; inputs funct3 and raw word; output formatted rdata. It is reused by the future cache path.
- Arbiter and FSM stay in bus_initiator.

Test Plan:
1. Reset, then fetch at 0x00000100; responder returns 0xDEADBEEF after 8 cycles → o_bus_DV once with o_bhw=100 and addr 0x100; o_if_ack with rdata 0xDEADBEEF one cycle after i_bus_DV.
2. LB at 0x2003; responder returns 0xAABBCC80 → bhw=001; o_ls_rdata=0xFFFFFF80. Repeat as LBU → 0x00000080. Repeat LH on 0xAABB8001 → 0xFFFF8001; LHU → 0x00008001.
3. SH of 0x12345678 at 0x3001 → o_write_notread=1, o_bhw=010, o_bus_data=0x12345678; o_ls_ack after completion; o_ls_rdata=0.
4. Both ports request continuously for 4 transactions → grants alternate IF, LS, IF, LS; never two strobes before one completion.
5. Responder never answers at addr 0x7000_0000 → o_fault rises exactly TIMEOUT_CYCLES cycles into WAIT; o_fault_addr=0x70000000; no further o_bus_DV; i_rst clears o_fault.
6. Assert i_rst during WAIT, then inject a stray i_bus_DV → no ack produced; the next fetch proceeds normally. Also LS funct3=011 → ack next cycle, rdata 0, no o_bus_DV.

Source files
------------

// File: rtl/bus_initiator_pkg.sv
// Shared constants for the byte-serial bus initiator: width codes, RISC-V load/store
// funct3 codes, FSM state encodings and the default timeout.
package bus_initiator_pkg;

    localparam logic [2:0] BHW_WORD = 3'b100;
    localparam logic [2:0] BHW_HALF = 3'b010;
    localparam logic [2:0] BHW_BYTE = 3'b001;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    localparam int TIMEOUT_DEFAULT = 4096;

    function automatic logic f3_valid(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic [2:0] f3_to_bhw(input logic [2:0] f3);
        logic [2:0] bhw;
        case (f3)
            F3_B, F3_BU: bhw = BHW_BYTE;
            F3_H, F3_HU: bhw = BHW_HALF;
            default:     bhw = BHW_WORD;
        endcase
        return bhw;
    endfunction

endpackage

// File: rtl/bus_initiator_load_extender.sv
// Formats a raw little-endian bus word into load data: masks unused upper bytes and
// applies sign or zero extension according to the RISC-V funct3 width code.
module load_extender
    import bus_initiator_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_data,
    output logic [31:0] o_data
);

    logic signed [7:0]  w_byte;
    logic signed [15:0] w_half;

    assign w_byte = i_data[7:0];
    assign w_half = i_data[15:0];

    always_comb begin
        o_data = '0;
        case (i_funct3)
            F3_B:    o_data = 32'(w_byte);
            F3_BU:   o_data = {24'b0, i_data[7:0]};
            F3_H:    o_data = 32'(w_half);
            F3_HU:   o_data = {16'b0, i_data[15:0]};
            F3_W:    o_data = i_data;
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/bus_initiator.sv
// Master end of the byte-serial memory bus: round-robin arbitration between fetch and
// load/store, one outstanding transaction at a time, read formatting and hang detection.
module bus_initiator
    import bus_initiator_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter int CNT_W          = 13
)
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    output logic        o_if_ack,
    output logic [31:0] o_if_rdata,
    input  logic        i_ls_req,
    input  logic        i_ls_we,
    input  logic [2:0]  i_ls_funct3,
    input  logic [31:0] i_ls_addr,
    input  logic [31:0] i_ls_wdata,
    output logic        o_ls_ack,
    output logic [31:0] o_ls_rdata,
    output logic [31:0] o_bus_data,
    output logic [31:0] o_bus_address,
    output logic        o_bus_DV,
    output logic [2:0]  o_bhw,
    output logic        o_write_notread,
    input  logic [31:0] i_bus_data,
    input  logic        i_bus_DV,
    output logic        o_fault,
    output logic [31:0] o_fault_addr
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       r_state;
    logic             r_last_ls;
    logic             r_grant_ls;
    logic [2:0]       r_funct3;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_bus_addr;
    logic [31:0]      r_bus_data;
    logic [2:0]       r_bhw;
    logic             r_write;
    logic             r_if_ack;
    logic             r_ls_ack;
    logic [31:0]      r_if_rdata;
    logic [31:0]      r_ls_rdata;
    logic             r_fault;
    logic [31:0]      r_fault_addr;

    logic             w_if_pend;
    logic             w_ls_pend;
    logic             w_pick_ls;
    logic             w_ls_bad;
    logic [31:0]      w_ext;

    // A port whose ack is on the wire this cycle still holds req; it must not be re-granted.
    assign w_if_pend = i_if_req & ~r_if_ack;
    assign w_ls_pend = i_ls_req & ~r_ls_ack;
    assign w_pick_ls = w_ls_pend & (~w_if_pend | ~r_last_ls);
    assign w_ls_bad  = ~f3_valid(i_ls_funct3);

    load_extender u_load_extender (
        .i_funct3 (r_funct3),
        .i_data   (i_bus_data),
        .o_data   (w_ext)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_last_ls    <= 1'b1;
            r_grant_ls   <= 1'b0;
            r_funct3     <= '0;
            r_cnt        <= '0;
            r_bus_addr   <= '0;
            r_bus_data   <= '0;
            r_bhw        <= '0;
            r_write      <= 1'b0;
            r_if_ack     <= 1'b0;
            r_ls_ack     <= 1'b0;
            r_if_rdata   <= '0;
            r_ls_rdata   <= '0;
            r_fault      <= 1'b0;
            r_fault_addr <= '0;
        end else begin
            r_if_ack   <= 1'b0;
            r_ls_ack   <= 1'b0;
            r_if_rdata <= '0;
            r_ls_rdata <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_if_pend || w_ls_pend) begin
                        r_last_ls  <= w_pick_ls;
                        r_grant_ls <= w_pick_ls;
                        if (w_pick_ls && w_ls_bad) begin
                            r_ls_ack <= 1'b1;
                        end else begin
                            r_bus_addr <= w_pick_ls ? i_ls_addr : i_if_addr;
                            r_bus_data <= (w_pick_ls && i_ls_we) ? i_ls_wdata : '0;
                            r_bhw      <= w_pick_ls ? f3_to_bhw(i_ls_funct3) : BHW_WORD;
                            r_write    <= w_pick_ls & i_ls_we;
                            r_funct3   <= w_pick_ls ? i_ls_funct3 : F3_W;
                            r_state    <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_bus_DV) begin
                        r_state <= S_IDLE;
                        if (r_grant_ls) begin
                            r_ls_ack   <= 1'b1;
                            r_ls_rdata <= r_write ? '0 : w_ext;
                        end else begin
                            r_if_ack   <= 1'b1;
                            r_if_rdata <= w_ext;
                        end
                    end else if (r_cnt == CNT_LAST) begin
                        r_fault      <= 1'b1;
                        r_fault_addr <= r_bus_addr;
                        r_state      <= S_FAULT;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_FAULT: begin
                    r_state <= S_FAULT;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_bus_DV        = (r_state == S_ISSUE);
    assign o_bus_address   = r_bus_addr;
    assign o_bus_data      = r_bus_data;
    assign o_bhw           = r_bhw;
    assign o_write_notread = r_write;
    assign o_if_ack        = r_if_ack;
    assign o_if_rdata      = r_if_rdata;
    assign o_ls_ack        = r_ls_ack;
    assign o_ls_rdata      = r_ls_rdata;
    assign o_fault         = r_fault;
    assign o_fault_addr    = r_fault_addr;

endmodule
